// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing readout blocks: FSM encoding,
// default word width and count-to-binary scaling.
package sc_pkg;

    localparam int SC_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } p2b_state_e;

    // Map a ones count over 2^win_log2 samples to a width-bit word. Unipolar is
    // an unsigned fraction, bipolar is signed Q1.(width-1); a full count saturates.
    function automatic logic [63:0] sc_scale(input logic [31:0] cnt, input logic bip,
                                             input int width, input int win_log2);
        logic [63:0] n, full, r;
        n    = 64'd1 << win_log2;
        full = (64'd1 << width) - 64'd1;
        if ({32'd0, cnt} >= n)
            r = bip ? (full >> 1) : full;
        else if (!bip)
            r = {32'd0, cnt} << (width - win_log2);
        else
            r = ({31'd0, cnt, 1'b0} - n) << (width - 1 - win_log2);
        return r & full;
    endfunction

endpackage

// File: rtl/p2b_window_counter.sv
// Qualified-sample and ones counters for one conversion window, with the
// window-end strobe raised on the sample that completes the window.
module p2b_window_counter #(
    parameter int WIN_LOG2 = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              bit_i,
    output logic [WIN_LOG2:0] cnt_o,
    output logic              win_end_o
);

    logic [WIN_LOG2-1:0] smp_q;
    logic [WIN_LOG2:0]   ones_q;

    // Final count includes the bit arriving on the window-end edge.
    assign cnt_o     = ones_q + {{WIN_LOG2{1'b0}}, bit_i};
    assign win_end_o = en_i & (&smp_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_q  <= '0;
            ones_q <= '0;
        end else if (clr_i || win_end_o) begin
            smp_q  <= '0;
            ones_q <= '0;
        end else if (en_i) begin
            smp_q  <= smp_q + 1'b1;
            ones_q <= cnt_o;
        end
    end

endmodule

// File: rtl/pulse_to_binary.sv
// Stochastic bitstream to binary converter: counts ones over 2^WIN_LOG2
// qualified samples and presents the scaled result on a valid/ready port.
module pulse_to_binary
    import sc_pkg::*;
#(
    parameter int WIDTH    = SC_WIDTH,
    parameter int WIN_LOG2 = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_en,
    input  logic             bipolar,
    input  logic             cont,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    p2b_state_e        state_q;
    logic              bip_q;
    logic [WIDTH-1:0]  y_q, y_d;
    logic              valid_q, overrun_q;
    logic              accum, win_end, xfer;
    logic [WIN_LOG2:0] cnt;

    assign accum = (state_q == ST_ACCUM);
    assign xfer  = valid_q & out_ready;
    assign y_d   = WIDTH'(sc_scale(32'(cnt), bip_q, WIDTH, WIN_LOG2));

    p2b_window_counter #(.WIN_LOG2(WIN_LOG2)) u_win (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (~accum),
        .en_i      (accum & bit_en),
        .bit_i     (bit_in),
        .cnt_o     (cnt),
        .win_end_o (win_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bip_q     <= 1'b0;
            y_q       <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (xfer) valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (start) begin
                    state_q   <= ST_ACCUM;
                    bip_q     <= bipolar;
                    overrun_q <= 1'b0;
                end
                ST_ACCUM: if (win_end) begin
                    // A same-edge transfer lets the new result in without overrun.
                    y_q     <= y_d;
                    valid_q <= 1'b1;
                    if (valid_q && !xfer) overrun_q <= 1'b1;
                    state_q <= cont ? ST_ACCUM : ST_HOLD;
                end
                ST_HOLD: if (xfer) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign y_out     = y_q;
    assign out_valid = valid_q;
    assign busy      = accum;
    assign overrun   = overrun_q;

endmodule

// File: doc/pulse_to_binary.md
Name: pulse_to_binary

Overview:
- Converts a stochastic bitstream back into a WIDTH-bit binary value by counting ones over a window of 2^WIN_LOG2 qualified samples. It is the inverse of the binary-to-pulse converter.
- It sits after the reservoir's stochastic datapath and feeds the readout and training logic.
- Supports unipolar and bipolar encodings, single-shot or continuous windows, and a valid/ready output handshake.

Parameters:
- WIDTH, 16, output word width.
- WIN_LOG2, 8, log2 of window length N = 2^WIN_LOG2. Legal range is 1..WIDTH-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a window; sampled only in IDLE.
- bit_in  in  1  stochastic bit.
- bit_en  in  1  qualifies bit_in; only cycles with bit_en=1 are samples.
- bipolar  in  1  encoding select; latched at start.
- cont  in  1  continuous mode; re-sampled at every window end.
- out_ready  in  1  consumer accepts y_out.
- y_out  out  WIDTH  converted value.
- out_valid  out  1  y_out holds an unaccepted result.
- busy  out  1  high in ACCUM.
- overrun  out  1  sticky flag; a result was overwritten before it was accepted.

Behaviour:
- Reset (async, immediate): y_out=0, out_valid=0, busy=0, overrun=0. State goes to IDLE; sample counter and ones counter are cleared. Reset mid-window discards the partial count and emits no result.
- FSM states are IDLE, ACCUM and HOLD.
- IDLE:
  - start=1 at edge k -> ACCUM from edge k+1; bipolar is latched; counters are cleared; overrun is cleared.
  - The bit present during the start cycle is not counted.
- ACCUM:
  - On each edge with bit_en=1: sample counter +1 and ones counter += bit_in.
  - On edges with bit_en=0: no change; bit_in is ignored.
  - start is ignored in ACCUM.
- Window end is the edge where the sample counter goes from N-1 to N. On that edge, y_out is loaded with the scaled final count (including the last bit) and out_valid goes to 1. Both are visible the following cycle.
  - If cont=1 at that edge: stay in ACCUM with counters cleared; the next qualified sample starts a new window.
  - If cont=0: go to HOLD.
- HOLD: when out_valid & out_ready -> out_valid=0 and go to IDLE. start is ignored in HOLD.
- Handshake:
  - Transfer occurs on an edge with out_valid & out_ready.
  - y_out is stable while out_valid=1 and no new result is loaded.
  - y_out retains its last value after transfer.
- Continuous overrun:
  - Window end while out_valid=1 and no transfer on the same edge -> y_out overwritten, out_valid stays 1, overrun set.
  - If a transfer and a window end occur on the same edge, the new result wins: out_valid stays 1 and there is no overrun.
- Unipolar scaling, with c = ones count (0..N, WIN_LOG2+1 bits):
  - y = c << (WIDTH-WIN_LOG2).
  - c=N saturates to all-ones (0xFFFF for defaults).
- Bipolar scaling, signed Q1.(WIDTH-1):
  - y = (2c-N) << (WIDTH-1-WIN_LOG2).
  - c=N saturates to 0x7FFF.
  - c=0 gives 0x8000.
- cont dropped mid-window: the current window completes, then the FSM enters HOLD.
- Latency: from start at edge k with bit_en held at 1, out_valid is visible after edge k+N.

Decomposition:
- Shared package sc_pkg: FSM state encoding localparams, WIDTH default, and a scale function (count, bipolar -> WIDTH-bit value with saturation). The package is reused by future stochastic readout blocks.
- One sub-module, p2b_window_counter, holds the qualified-sample counter, the ones counter and the window-end strobe. It is instantiated once.

Test Plan (defaults WIDTH=16, WIN_LOG2=8):
1. Unipolar, bit_en=1, bit_in=1 for 256 samples -> y_out=0xFFFF. out_valid rises exactly 256 edges after the start edge. busy falls at the same time.
2. Alternating 1/0, 128 ones:
   - unipolar -> y_out=0x8000;
   - bipolar -> y_out=0x0000.
3. Bipolar extremes:
   - all zeros -> 0x8000;
   - all ones -> 0x7FFF;
   - 64 ones -> 0xC000.
4. bit_en toggling every cycle, bit_in=1 only when bit_en=0 -> window spans 512 cycles and y_out=0x0000.
5. cont=1, out_ready=0, first window 256 ones then second window 0 ones:
   - after the first window, out_valid=1 and y_out=0xFFFF;
   - after the second window, y_out=0x0000, overrun=1, out_valid still 1;
   - out_ready=1 then clears out_valid;
   - a new start clears overrun.
6. rst pulsed after 100 samples:
   - y_out, out_valid and busy are 0 within the reset cycle, with no clock edge needed;
   - a new start with 200 ones then yields 0xC800.
